// File: rtl/float_contract_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : float_contract_arbiter_if
// Purpose  : Bundles the requester-side and writeback-side handshake signals
//            of float_contract_arbiter.
// Revision : 1.0 - initial release
// Ports    : inValid/inData/inReady - NUM_REQ requesters, packed data slices
//            outValid/outReady/outData/outTag/outIsNan/outInexact - result
//            statClear/statInexact/statOverflow - only when
//            FLOAT_CONTRACT_ARB_STATS_EN is defined
// Modports : master - requester/writeback side (drives inputs of the DUT)
//            slave  - arbiter side
// ============================================================================
interface float_contract_arbiter_if #(
  parameter int NUM_REQ  = 2,
  parameter int EXP_IN   = 11,
  parameter int FRAC_IN  = 52,
  parameter int EXP_OUT  = 8,
  parameter int FRAC_OUT = 23,
  parameter int TAG_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                      inValid;
  logic [NUM_REQ*(1+EXP_IN+FRAC_IN)-1:0]   inData;
  logic [NUM_REQ-1:0]                      inReady;
  logic                                    outValid;
  logic                                    outReady;
  logic [EXP_OUT+FRAC_OUT:0]               outData;
  logic [TAG_W-1:0]                        outTag;
  logic                                    outIsNan;
  logic                                    outInexact;
`ifdef FLOAT_CONTRACT_ARB_STATS_EN
  logic                                    statClear;
  logic [31:0]                             statInexact;
  logic [31:0]                             statOverflow;
`endif

  modport master (
    output inValid, inData, outReady,
`ifdef FLOAT_CONTRACT_ARB_STATS_EN
    output statClear,
    input  statInexact, statOverflow,
`endif
    input  inReady, outValid, outData, outTag, outIsNan, outInexact
  );

  modport slave (
    input  inValid, inData, outReady,
`ifdef FLOAT_CONTRACT_ARB_STATS_EN
    input  statClear,
    output statInexact, statOverflow,
`endif
    output inReady, outValid, outData, outTag, outIsNan, outInexact
  );
endinterface
`default_nettype wire

// File: rtl/float_contract_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : float_contract_arbiter
// Purpose  : Round-robin shares one wide->narrow float contraction datapath
//            between NUM_REQ requesters, with round-to-nearest-even and a
//            two-stage valid/ready pipeline returning the requester tag.
// Revision : 1.0 - initial release
// Ports    : clock  - rising-edge clock
//            resetn - asynchronous active-low reset
//            bus    - float_contract_arbiter_if.slave (requests + result)
// Option   : FLOAT_CONTRACT_ARB_STATS_EN adds saturating inexact/overflow
//            result counters with a synchronous clear (statClear).
// ============================================================================
module float_contract_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int EXP_IN   = 11,
  parameter int FRAC_IN  = 52,
  parameter int EXP_OUT  = 8,
  parameter int FRAC_OUT = 23,
  parameter int TAG_W    = $clog2(NUM_REQ)
) (
  input wire                      clock,
  input wire                      resetn,
  float_contract_arbiter_if.slave bus
);
  localparam int IN_W        = 1 + EXP_IN + FRAC_IN;
  localparam int OUT_W       = 1 + EXP_OUT + FRAC_OUT;
  localparam int MAG_W       = EXP_OUT + FRAC_OUT;
  localparam int DROP        = FRAC_IN - FRAC_OUT;   // dropped fraction bits (>= 3)
  localparam int BIAS_DELTA  = (2**(EXP_IN-1) - 1) - (2**(EXP_OUT-1) - 1);
  localparam int EXP_OUT_MAX = 2**EXP_OUT - 1;

  // ---------------------------------------------------------------- arbiter
  logic [TAG_W-1:0]   rrPtr_q, rrPtr_d;
  logic [TAG_W-1:0]   grantIdx;
  logic               grantFound;
  logic [NUM_REQ-1:0] inReadyW;
  logic [IN_W-1:0]    selWord;
  logic               s1Advance, s1Accept, inHandshake;

  logic               s1Valid_q;
  logic [IN_W-1:0]    s1Data_q;
  logic [TAG_W-1:0]   s1Tag_q;

  logic               outValid_q;
  logic [OUT_W-1:0]   outData_q;
  logic [TAG_W-1:0]   outTag_q;
  logic               outIsNan_q, outInexact_q, outOverflow_q;

  assign s1Advance   = !outValid_q || bus.outReady;
  assign s1Accept    = !s1Valid_q || s1Advance;
  assign inHandshake = s1Accept && grantFound;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    int               sum;
    logic [TAG_W-1:0] idx;
    sum        = 0;
    idx        = '0;
    grantIdx   = '0;
    grantFound = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rrPtr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = TAG_W'(sum);
      if (!grantFound && bus.inValid[idx]) begin
        grantFound = 1'b1;
        grantIdx   = idx;
      end
    end
  end

  always_comb begin
    inReadyW = '0;
    selWord  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == TAG_W'(i)) begin
        selWord = bus.inData[i*IN_W +: IN_W];
        if (inHandshake) inReadyW[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (inHandshake)
      rrPtr_d = (grantIdx == TAG_W'(NUM_REQ-1)) ? '0 : grantIdx + 1'b1;
  end

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Tag_q   <= '0;
      rrPtr_q   <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
      if (s1Accept) begin
        s1Valid_q <= inHandshake;
        if (inHandshake) begin
          s1Data_q <= selWord;
          s1Tag_q  <= grantIdx;
        end
      end
    end
  end

  // -------------------------------------------------- contract + RNE round
  logic                 inSign;
  logic [EXP_IN-1:0]    inExp;
  logic [FRAC_IN-1:0]   inFrac;
  logic [FRAC_OUT-1:0]  ctFrac;
  logic [1:0]           trailingBits;
  logic                 stickyBit;
  logic                 roundUp;
  logic [MAG_W-1:0]     roundedMag;
  int                   expAdj;
  logic [OUT_W-1:0]     res_d;
  logic                 nan_d, inexact_d, overflow_d;

  assign {inSign, inExp, inFrac} = s1Data_q;
  assign ctFrac       = inFrac[FRAC_IN-1 -: FRAC_OUT];
  assign trailingBits = inFrac[DROP-1 -: 2];
  assign stickyBit    = |inFrac[DROP-3:0];
  assign roundUp      = trailingBits[1] & (trailingBits[0] | stickyBit | ctFrac[0]);

  always_comb begin
    expAdj     = int'(inExp) - BIAS_DELTA;
    // A fraction carry ripples into the exponent; from exponent max-1 it
    // lands exactly on the infinity encoding.
    roundedMag = {EXP_OUT'(expAdj), ctFrac} + MAG_W'(roundUp);
    res_d      = '0;
    nan_d      = 1'b0;
    inexact_d  = 1'b0;
    overflow_d = 1'b0;
    if (&inExp) begin
      if (|inFrac) begin
        res_d = {inSign, {EXP_OUT{1'b1}}, 1'b1, {(FRAC_OUT-1){1'b0}}};
        nan_d = 1'b1;
      end else begin
        res_d = {inSign, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}};
      end
    end else if (expAdj >= EXP_OUT_MAX) begin
      res_d      = {inSign, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}};
      inexact_d  = 1'b1;
      overflow_d = 1'b1;
    end else if (expAdj <= 0) begin
      // Below the narrow normal range: flush to signed zero.
      res_d     = {inSign, {MAG_W{1'b0}}};
      inexact_d = (|inExp) | (|inFrac);
    end else begin
      res_d      = {inSign, roundedMag};
      overflow_d = &roundedMag[MAG_W-1 -: EXP_OUT];
      inexact_d  = (|trailingBits) | stickyBit | overflow_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      outValid_q    <= 1'b0;
      outData_q     <= '0;
      outTag_q      <= '0;
      outIsNan_q    <= 1'b0;
      outInexact_q  <= 1'b0;
      outOverflow_q <= 1'b0;
    end else if (s1Advance) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outData_q     <= res_d;
        outTag_q      <= s1Tag_q;
        outIsNan_q    <= nan_d;
        outInexact_q  <= inexact_d;
        outOverflow_q <= overflow_d;
      end
    end
  end

  assign bus.inReady    = inReadyW;
  assign bus.outValid   = outValid_q;
  assign bus.outData    = outData_q;
  assign bus.outTag     = outTag_q;
  assign bus.outIsNan   = outIsNan_q;
  assign bus.outInexact = outInexact_q;

`ifdef FLOAT_CONTRACT_ARB_STATS_EN
  logic [31:0] statInexact_q, statOverflow_q;
  logic        outFire;
  assign outFire = outValid_q && bus.outReady;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      statInexact_q  <= '0;
      statOverflow_q <= '0;
    end else if (bus.statClear) begin
      statInexact_q  <= '0;
      statOverflow_q <= '0;
    end else if (outFire) begin
      if (outInexact_q && (statInexact_q != '1))   statInexact_q  <= statInexact_q + 1'b1;
      if (outOverflow_q && (statOverflow_q != '1)) statOverflow_q <= statOverflow_q + 1'b1;
    end
  end

  assign bus.statInexact  = statInexact_q;
  assign bus.statOverflow = statOverflow_q;
`else
  logic unusedOverflow;
  assign unusedOverflow = outOverflow_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_float_contract_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_float_contract_arbiter
// Purpose  : Directed self-checking bench for float_contract_arbiter
//            (default two requesters, double -> single narrowing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_contract_arbiter;
  localparam int N = 2;

  logic clock;
  logic resetn;
  int   vectors;
  int   miscompares;

  float_contract_arbiter_if bus ();

  float_contract_arbiter dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic setWord(input int req, input logic [63:0] word);
    if (req == 0) bus.inData[63:0]   = word;
    else          bus.inData[127:64] = word;
  endtask

  // One lone request with outReady high: grant, 2-cycle latency, result.
  task automatic run1(input string tag, input int req, input logic [63:0] word,
                      input logic [31:0] expData, input logic expNan, input logic expInex);
    bus.inValid = N'(1 << req);
    setWord(req, word);
    #1;
    check({tag, "_inReady"}, 64'(bus.inReady), 64'(1 << req));
    tick();
    bus.inValid = '0;
    tick();
    check({tag, "_outValid"},   64'(bus.outValid),   64'd1);
    check({tag, "_outData"},    64'(bus.outData),    64'(expData));
    check({tag, "_outTag"},     64'(bus.outTag),     64'(req));
    check({tag, "_outIsNan"},   64'(bus.outIsNan),   64'(expNan));
    if (!expNan)
      check({tag, "_outInexact"}, 64'(bus.outInexact), 64'(expInex));
    tick();
    check({tag, "_drained"},    64'(bus.outValid),   64'd0);
  endtask

  logic [31:0] arbData [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    bus.inValid  = '0;
    bus.inData   = '0;
    bus.outReady = 1'b1;
`ifdef FLOAT_CONTRACT_ARB_STATS_EN
    bus.statClear = 1'b0;
`endif
    // ---------------------------------------------------------- reset state
    tick(); tick();
    check("rst_outValid",   64'(bus.outValid),   64'd0);
    check("rst_outData",    64'(bus.outData),    64'd0);
    check("rst_outTag",     64'(bus.outTag),     64'd0);
    check("rst_outIsNan",   64'(bus.outIsNan),   64'd0);
    check("rst_outInexact", 64'(bus.outInexact), 64'd0);
    check("rst_inReady",    64'(bus.inReady),    64'd0);
    resetn = 1'b1;
    tick();

    // ------------------------------------------------------ datapath cases
    run1("one",       0, 64'h3FF0000000000000, 32'h3F800000, 1'b0, 1'b0); // ptr -> 1
    run1("tie_odd",   0, 64'h3FF0000030000000, 32'h3F800002, 1'b0, 1'b1); // wrap, ptr -> 1
    run1("tie_even",  1, 64'h3FF0000010000000, 32'h3F800000, 1'b0, 1'b1); // ptr -> 0
    run1("ovf_range", 1, 64'h7FEFFFFFFFFFFFFF, 32'h7F800000, 1'b0, 1'b1); // lone req1 at ptr 0
    run1("nan",       0, 64'h7FF0000000000001, 32'h7FC00000, 1'b1, 1'b0); // ptr -> 1
    run1("neg_inf",   1, 64'hFFF0000000000000, 32'hFF800000, 1'b0, 1'b0); // ptr -> 0
    run1("carry_exp", 0, 64'h3FFFFFFFF0000000, 32'h40000000, 1'b0, 1'b1); // ptr -> 1
    run1("ovf_round", 1, 64'h47EFFFFFF0000000, 32'h7F800000, 1'b0, 1'b1); // ptr -> 0
    run1("neg_zero",  1, 64'h8000000000000000, 32'h80000000, 1'b0, 1'b0); // ptr -> 0

    // ------------------------------------- round robin, both always valid
    arbData[0] = 32'h3F800000;
    arbData[1] = 32'h40000000;
    arbData[2] = 32'h3F800000;
    arbData[3] = 32'h40000000;
    setWord(0, 64'h3FF0000000000000);
    setWord(1, 64'h4000000000000000);
    bus.inValid = 2'b11;
    #1;
    check("rr_grant0", 64'(bus.inReady), 64'd1);
    tick();
    check("rr_grant1", 64'(bus.inReady), 64'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) bus.inValid = '0;  // four handshakes taken by now
      check($sformatf("rr_valid%0d", i), 64'(bus.outValid), 64'd1);
      check($sformatf("rr_tag%0d", i),   64'(bus.outTag),   64'(i % 2));
      check($sformatf("rr_data%0d", i),  64'(bus.outData),  64'(arbData[i]));
    end
    tick();
    check("rr_drained", 64'(bus.outValid), 64'd0);

    // ------------------------------------------------------- backpressure
    bus.outReady = 1'b0;
    setWord(0, 64'h3FF0000000000000);           // A -> 3F800000
    setWord(1, 64'h4000000000000000);           // B -> 40000000
    bus.inValid = 2'b11;
    tick();                                     // A accepted
    check("bp_accept2", 64'(bus.inReady), 64'd2);
    setWord(0, 64'hBFF8000000000000);           // C -> BFC00000
    tick();                                     // A to output, B held in stage 1
    bus.inValid = 2'b01;
    #1;
    check("bp_full_inReady", 64'(bus.inReady), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), 64'(bus.outValid), 64'd1);
      check($sformatf("bp_hold_data%0d", i),  64'(bus.outData),  64'h3F800000);
      check($sformatf("bp_hold_tag%0d", i),   64'(bus.outTag),   64'd0);
      check($sformatf("bp_hold_rdy%0d", i),   64'(bus.inReady),  64'd0);
    end
    bus.outReady = 1'b1;
    #1;
    check("bp_release_rdy", 64'(bus.inReady), 64'd1);
    tick();                                     // B out, C accepted
    bus.inValid = '0;
    check("bp_out_B_data", 64'(bus.outData), 64'h40000000);
    check("bp_out_B_tag",  64'(bus.outTag),  64'd1);
    tick();
    check("bp_out_C_valid", 64'(bus.outValid), 64'd1);
    check("bp_out_C_data",  64'(bus.outData),  64'hBFC00000);
    check("bp_out_C_tag",   64'(bus.outTag),   64'd0);
    tick();
    check("bp_drained", 64'(bus.outValid), 64'd0);

    // ------------------------------------------------- reset mid-stream
    setWord(0, 64'h3FF0000000000000);
    bus.inValid = 2'b01;
    tick();
    tick();
    check("mrst_pre_valid", 64'(bus.outValid), 64'd1);
    resetn = 1'b0;
    #1;
    check("mrst_outValid", 64'(bus.outValid), 64'd0);
    check("mrst_outData",  64'(bus.outData),  64'd0);
    bus.inValid = '0;
    tick();
    resetn = 1'b1;
    tick();
    check("mrst_no_replay", 64'(bus.outValid), 64'd0);
    setWord(0, 64'hBFF8000000000000);
    setWord(1, 64'h4000000000000000);
    bus.inValid = 2'b11;
    #1;
    check("mrst_ptr0_grant", 64'(bus.inReady), 64'd1);
    tick();
    bus.inValid = '0;
    tick();
    check("mrst_first_valid", 64'(bus.outValid), 64'd1);
    check("mrst_first_data",  64'(bus.outData),  64'hBFC00000);
    check("mrst_first_tag",   64'(bus.outTag),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/float_contract_arbiter.md
Name: float_contract_arbiter

Overview:
- Shares one FloatContract narrowing datapath (e.g. double->float) between NUM_REQ requesters using round-robin arbitration.
- Adds round-to-nearest-even using the contract's trailing/sticky bits.
- Two-stage valid/ready pipeline with a requester tag returned alongside each result.
- Sits between accumulator readout ports and the narrow-format writeback path.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- EXP_IN, 11, input exponent width.
- FRAC_IN, 52, input fraction width.
- EXP_OUT, 8, output exponent width.
- FRAC_OUT, 23, output fraction width.
- TAG_W, $clog2(NUM_REQ), width of the returned requester index.

Ports:
- clock  in  1  single clock; all logic rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- inValid  in  NUM_REQ  per-requester valid.
- inData  in  NUM_REQ*(1+EXP_IN+FRAC_IN)  packed inputs; requester i occupies slice i.
- inReady  out  NUM_REQ  per-requester ready; one-hot or zero.
- outValid  out  1  result valid.
- outReady  in  1  downstream ready.
- outData  out  1+EXP_OUT+FRAC_OUT  rounded narrowed value.
- outTag  out  TAG_W  index of the requester that produced outData.
- outIsNan  out  1  input was NaN.
- outInexact  out  1  trailing or sticky bits were nonzero.

Behaviour:
- Reset (async on resetn low): outValid=0, outData=0, outTag=0, outIsNan=0, outInexact=0, stage-1 valid=0, round-robin pointer=0. All in-flight data is discarded; nothing is replayed after reset.
- Stage advance: s1Advance = !s2Valid | outReady. Stage 1 accepts when !s1Valid | s1Advance.
- Arbitration (combinational):
  - When stage 1 accepts, grant the first requester with inValid set, searching from the pointer upward with wrap-around.
  - inReady[g]=1 for the granted index only; all others 0.
  - No request, or stage 1 cannot accept -> inReady=0.
- Pointer update: on a handshake (inValid[g]&inReady[g]), pointer <= (g+1) mod NUM_REQ. Otherwise the pointer holds.
- Stage 1: registers the selected input word and tag.
- Stage 2: FloatContract on the stage-1 word, then RNE rounding; result registered into the out* regs on s1Advance.
- Rounding: lsb = contracted fraction[0], g = trailingBits[1], r|s = trailingBits[0]|stickyBit.
  - roundUp = g & (r|s|lsb).
  - Add roundUp to {exponent,fraction} as one EXP_OUT+FRAC_OUT-bit integer; a carry into the all-ones exponent yields infinity (fraction 0).
  - Inf: passes through unrounded.
  - NaN: output is canonical quiet NaN {sign,all-ones exponent,1,0...}; outIsNan=1; no rounding.
  - Input exponent above output range -> signed infinity, outInexact=1.
- outInexact = |trailingBits | stickyBit; forced 1 on overflow-to-inf.
- Latency: 2 cycles from input handshake to outValid with outReady held high. Throughput is 1/cycle.
- Backpressure: while outValid & !outReady, out* regs stay stable. Stage 1 holds if full; inReady=0 once both stages are full.
- Simultaneous events: input handshake and output drain in the same cycle are legal; full throughput is kept.

Optional Feature:
- Macro: FLOAT_CONTRACT_ARB_STATS_EN.
- Defined:
  - Adds output ports statInexact[31:0] and statOverflow[31:0].
  - Both are saturating counters, incremented on each output handshake where outInexact (resp. overflow-to-inf) is set.
  - Both counters reset to 0 via resetn.
  - Adds input statClear, a synchronous clear with priority over increment.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Double 0x3FF0000000000000 on req0, outReady=1 -> after 2 cycles outData=0x3F800000, outTag=0, outInexact=0.
- Ties:
  - 0x3FF0000030000000 (lsb=1, tie) -> 0x3F800002, inexact=1.
  - 0x3FF0000010000000 (lsb=0, tie) -> 0x3F800000, inexact=1.
- Overflow and NaN:
  - 0x7FEFFFFFFFFFFFFF -> 0x7F800000, outInexact=1.
  - 0x7FF0000000000001 -> 0x7FC00000, outIsNan=1.
- Arbitration:
  - req0 and req1 continuously valid for 4 handshakes -> outTag sequence 0,1,0,1.
  - A lone req1 after pointer=0 is granted immediately.
- Backpressure: outReady=0 for 3 cycles with 3 queued inputs -> outData/outTag stable; inReady=0 after 2 accepts. Release -> results arrive in order, none lost or duplicated.
- Reset: resetn pulsed low mid-stream -> outValid=0 immediately. After release, the first new input is the first output and the pointer is 0.
